z80_mem_cycle: RTL and testbench

Z80 external bus machine-cycle generator: the far end of the register file's internal address/data path. It takes a latched 16-bit address (PC, SP, IX, IY or a register pair) plus an optional write byte, runs one Z80 memory machine cycle (opcode fetch M1, memory read, or memory write) on the external pins with WAIT_N insertion and M1 refresh, and returns the read byte for loading into W, Z or the general register set. One T-state equals one CLK cycle.

---
 rtl/z80_mem_cycle.sv | 223 ++++++++++++++++++++++
 tb/tb_z80_mem_cycle.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/z80_mem_cycle.sv
// Z80 external bus machine-cycle generator: M1 fetch, memory read, memory write.
// Runs T1..T3 (plus T4 refresh for M1) with WAIT_N-driven TW insertion.
module z80_mem_cycle #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ,
    input  logic        REQ_WR,
    input  logic        REQ_M1,
    input  logic [15:0] ADDR_IN,
    input  logic [7:0]  WDATA,
    input  logic [7:0]  I_IN,
    input  logic [7:0]  R_IN,
    output logic        BUSY,
    output logic        DONE,
    output logic [7:0]  RDATA,
    output logic        TIMEOUT,
    output logic [15:0] ADDR_OUT,
    output logic [7:0]  DATA_OUT,
    output logic        DATA_OE,
    input  logic [7:0]  DATA_IN,
    input  logic        WAIT_N,
    output logic        MREQ_N,
    output logic        RD_N,
    output logic        WR_N,
    output logic        M1_N,
    output logic        RFSH_N
);

    typedef enum logic [2:0] {
        S_IDLE, S_T1, S_T2, S_TW, S_T3, S_T4
    } state_t;

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    state_t      r_state, w_state;
    logic        r_wr, w_wr;
    logic        r_m1, w_m1;
    logic [15:0] r_ir, w_ir;
    logic [7:0]  r_wcnt, w_wcnt;
    logic        r_tmo, w_tmo;
    logic        r_busy, w_busy;
    logic        r_done, w_done;
    logic        r_tout, w_tout;
    logic [15:0] r_addr, w_addr;
    logic [7:0]  r_dout, w_dout;
    logic [7:0]  r_rdata, w_rdata;
    logic        r_oe, w_oe;
    logic        r_mreq_n, w_mreq_n;
    logic        r_rd_n, w_rd_n;
    logic        r_wr_n, w_wr_n;
    logic        r_m1_n, w_m1_n;
    logic        r_rfsh_n, w_rfsh_n;
    logic        w_to_t3;
    logic        w_to_idle;

    always_comb begin
        w_state   = r_state;
        w_wr      = r_wr;
        w_m1      = r_m1;
        w_ir      = r_ir;
        w_wcnt    = r_wcnt;
        w_tmo     = r_tmo;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_tout    = 1'b0;
        w_addr    = r_addr;
        w_dout    = r_dout;
        w_rdata   = r_rdata;
        w_oe      = r_oe;
        w_mreq_n  = r_mreq_n;
        w_rd_n    = r_rd_n;
        w_wr_n    = r_wr_n;
        w_m1_n    = r_m1_n;
        w_rfsh_n  = r_rfsh_n;
        w_to_t3   = 1'b0;
        w_to_idle = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (REQ) begin
                    w_state  = S_T1;
                    w_wr     = REQ_WR;
                    w_m1     = REQ_M1 & ~REQ_WR;
                    w_ir     = {I_IN, R_IN};
                    w_wcnt   = 8'd0;
                    w_tmo    = 1'b0;
                    w_busy   = 1'b1;
                    w_addr   = ADDR_IN;
                    w_mreq_n = 1'b0;
                    w_rd_n   = REQ_WR;
                    w_m1_n   = ~(REQ_M1 & ~REQ_WR);
                    w_oe     = REQ_WR;
                    if (REQ_WR)
                        w_dout = WDATA;
                end
            end
            S_T1: begin
                w_state = S_T2;
                if (r_wr)
                    w_wr_n = 1'b0;
            end
            S_T2: begin
                if (!WAIT_N)
                    w_state = S_TW;
                else
                    w_to_t3 = 1'b1;
            end
            S_TW: begin
                if (r_wcnt != 8'hFF)
                    w_wcnt = r_wcnt + 8'd1;
                if (WAIT_N) begin
                    w_to_t3 = 1'b1;
                end else if (w_wcnt >= LIMIT) begin
                    w_to_t3 = 1'b1;
                    w_tmo   = 1'b1;
                end
            end
            S_T3: begin
                if (r_m1) begin
                    w_state  = S_T4;
                    w_mreq_n = 1'b1;
                    w_done   = 1'b1;
                    w_tout   = r_tmo;
                end else begin
                    if (!r_wr)
                        w_rdata = DATA_IN;
                    w_to_idle = 1'b1;
                end
            end
            S_T4:    w_to_idle = 1'b1;
            default: w_to_idle = 1'b1;
        endcase

        // M1 samples the opcode here and switches the bus to refresh
        if (w_to_t3) begin
            w_state = S_T3;
            if (r_m1) begin
                w_rdata  = DATA_IN;
                w_addr   = r_ir;
                w_rd_n   = 1'b1;
                w_m1_n   = 1'b1;
                w_rfsh_n = 1'b0;
            end else begin
                w_done = 1'b1;
                w_tout = w_tmo;
            end
        end

        if (w_to_idle) begin
            w_state  = S_IDLE;
            w_busy   = 1'b0;
            w_oe     = 1'b0;
            w_mreq_n = 1'b1;
            w_rd_n   = 1'b1;
            w_wr_n   = 1'b1;
            w_m1_n   = 1'b1;
            w_rfsh_n = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            r_state <= S_IDLE;
        else
            r_state <= w_state;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wr     <= 1'b0;
            r_m1     <= 1'b0;
            r_ir     <= 16'd0;
            r_wcnt   <= 8'd0;
            r_tmo    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_tout   <= 1'b0;
            r_addr   <= 16'd0;
            r_dout   <= 8'd0;
            r_rdata  <= 8'd0;
            r_oe     <= 1'b0;
            r_mreq_n <= 1'b1;
            r_rd_n   <= 1'b1;
            r_wr_n   <= 1'b1;
            r_m1_n   <= 1'b1;
            r_rfsh_n <= 1'b1;
        end else begin
            r_wr     <= w_wr;
            r_m1     <= w_m1;
            r_ir     <= w_ir;
            r_wcnt   <= w_wcnt;
            r_tmo    <= w_tmo;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_tout   <= w_tout;
            r_addr   <= w_addr;
            r_dout   <= w_dout;
            r_rdata  <= w_rdata;
            r_oe     <= w_oe;
            r_mreq_n <= w_mreq_n;
            r_rd_n   <= w_rd_n;
            r_wr_n   <= w_wr_n;
            r_m1_n   <= w_m1_n;
            r_rfsh_n <= w_rfsh_n;
        end
    end

    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign TIMEOUT  = r_tout;
    assign RDATA    = r_rdata;
    assign ADDR_OUT = r_addr;
    assign DATA_OUT = r_dout;
    assign DATA_OE  = r_oe;
    assign MREQ_N   = r_mreq_n;
    assign RD_N     = r_rd_n;
    assign WR_N     = r_wr_n;
    assign M1_N     = r_m1_n;
    assign RFSH_N   = r_rfsh_n;

endmodule

// File: tb/tb_z80_mem_cycle.sv
// Bench for z80_mem_cycle: directed and random machine cycles checked
// against a per-T-state bus waveform model derived from cycle kind and wait count.
module tb_z80_mem_cycle;

    localparam int LIM = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        REQ, REQ_WR, REQ_M1;
    logic [15:0] ADDR_IN;
    logic [7:0]  WDATA, I_IN, R_IN, DATA_IN;
    logic        WAIT_N;
    logic        BUSY, DONE, TIMEOUT, DATA_OE;
    logic [7:0]  RDATA, DATA_OUT;
    logic [15:0] ADDR_OUT;
    logic        MREQ_N, RD_N, WR_N, M1_N, RFSH_N;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  exp_rdata;

    z80_mem_cycle #(.WAIT_LIMIT(LIM)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ(REQ), .REQ_WR(REQ_WR), .REQ_M1(REQ_M1),
        .ADDR_IN(ADDR_IN), .WDATA(WDATA), .I_IN(I_IN), .R_IN(R_IN),
        .BUSY(BUSY), .DONE(DONE), .RDATA(RDATA), .TIMEOUT(TIMEOUT),
        .ADDR_OUT(ADDR_OUT), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE),
        .DATA_IN(DATA_IN), .WAIT_N(WAIT_N),
        .MREQ_N(MREQ_N), .RD_N(RD_N), .WR_N(WR_N),
        .M1_N(M1_N), .RFSH_N(RFSH_N)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bus at rest: strobes high, not driving, not busy
    task automatic check_idle(input string tag, input logic [15:0] ea,
                              input logic [7:0] erd, input logic [7:0] edo);
        chk({tag, ":ctl"}, 32'({BUSY, DONE, TIMEOUT, DATA_OE}), 32'(0));
        chk({tag, ":strb"}, 32'({MREQ_N, RD_N, WR_N, M1_N, RFSH_N}),
            32'(5'h1F));
        chk({tag, ":addr"}, 32'(ADDR_OUT), 32'(ea));
        chk({tag, ":rdata"}, 32'(RDATA), 32'(erd));
        chk({tag, ":dout"}, 32'(DATA_OUT), 32'(edo));
    endtask

    logic [7:0] exp_dout;

    // kind: 0 read, 1 write, 2 M1. n: number of WAIT_N-low samples.
    task automatic do_txn(input int kind, input logic [15:0] a,
                          input logic [7:0] wd, input logic [7:0] iv,
                          input logic [7:0] rv, input logic [7:0] din,
                          input int n, input int abort_at);
        int         w, len;
        bit         tmo;
        logic [4:0] es;
        logic [15:0] ea;
        string      t;
        w   = (n > LIM) ? LIM : n;
        tmo = (n > LIM);
        len = ((kind == 2) ? 4 : 3) + w;
        REQ     = 1'b1;
        REQ_WR  = (kind == 1);
        REQ_M1  = (kind == 2) ? 1'b1 :
                  (kind == 1) ? 1'($urandom_range(1)) : 1'b0;
        ADDR_IN = a;
        WDATA   = wd;
        I_IN    = iv;
        R_IN    = rv;
        DATA_IN = din;
        WAIT_N  = 1'($urandom_range(1));
        if (kind == 1)
            exp_dout = wd;
        for (int k = 1; k <= len; k++) begin
            @(negedge CLK);
            t = $sformatf("k%0d_a%04h_c%0d", kind, a, k);
            ea = a;
            if (kind == 0) begin
                es = 5'b00111;
            end else if (kind == 1) begin
                es = (k >= 2) ? 5'b01011 : 5'b01111;
            end else if (k <= 2 + w) begin
                es = 5'b00101;
            end else if (k == 3 + w) begin
                es = 5'b01110;
                ea = {iv, rv};
            end else begin
                es = 5'b11110;
                ea = {iv, rv};
            end
            chk({t, ":strb"}, 32'({MREQ_N, RD_N, WR_N, M1_N, RFSH_N}),
                32'(es));
            chk({t, ":addr"}, 32'(ADDR_OUT), 32'(ea));
            chk({t, ":bdt"}, 32'({BUSY, DONE, TIMEOUT}),
                32'({1'b1, k == len, (k == len) && tmo}));
            chk({t, ":oe"}, 32'(DATA_OE), 32'(kind == 1));
            if (kind == 1)
                chk({t, ":dout"}, 32'(DATA_OUT), 32'(wd));
            if (kind == 2 && k >= 3 + w)
                chk({t, ":rdata"}, 32'(RDATA), 32'(din));
            if (k == abort_at) begin
                #2 RESET = 1'b1;
                #1;
                exp_rdata = 8'h00;
                exp_dout  = 8'h00;
                check_idle({t, ":rst"}, 16'h0000, 8'h00, 8'h00);
                REQ = 1'b0;
                @(negedge CLK);
                check_idle({t, ":rsthold"}, 16'h0000, 8'h00, 8'h00);
                RESET = 1'b0;
                return;
            end
            // Scramble captured inputs and keep requesting while busy
            REQ     = 1'($urandom_range(1));
            REQ_WR  = 1'($urandom_range(1));
            REQ_M1  = 1'($urandom_range(1));
            ADDR_IN = 16'($urandom);
            WDATA   = 8'($urandom);
            I_IN    = 8'($urandom);
            R_IN    = 8'($urandom);
            if (k >= 2 && k <= n + 1)
                WAIT_N = 1'b0;
            else if (k >= 2 && k <= w + 2)
                WAIT_N = 1'b1;
            else
                WAIT_N = 1'($urandom_range(1));
        end
        if (kind != 1)
            exp_rdata = din;
        @(negedge CLK);
        check_idle($sformatf("k%0d_a%04h_idle", kind, a),
                   (kind == 2) ? {iv, rv} : a, exp_rdata, exp_dout);
        REQ = 1'b0;
    endtask

    initial begin
        RESET   = 1'b0;
        REQ     = 1'b0;
        REQ_WR  = 1'b0;
        REQ_M1  = 1'b0;
        ADDR_IN = 16'h0;
        WDATA   = 8'h0;
        I_IN    = 8'h0;
        R_IN    = 8'h0;
        DATA_IN = 8'h0;
        WAIT_N  = 1'b1;
        exp_rdata = 8'h00;
        exp_dout  = 8'h00;

        #1 RESET = 1'b1;
        #2;
        check_idle("reset", 16'h0000, 8'h00, 8'h00);
        @(negedge CLK);
        @(negedge CLK);
        check_idle("reset_hold", 16'h0000, 8'h00, 8'h00);
        RESET = 1'b0;

        do_txn(0, 16'h1234, 8'h00, 8'h00, 8'h00, 8'hA5, 0, 0);
        do_txn(1, 16'h8000, 8'h3C, 8'h00, 8'h00, 8'h00, 2, 0);
        do_txn(2, 16'h0000, 8'h00, 8'h12, 8'h34, 8'h3E, 0, 0);
        do_txn(0, 16'h5555, 8'h00, 8'h00, 8'h00, 8'h77, 6, 0);
        do_txn(2, 16'h4000, 8'h00, 8'hAB, 8'hCD, 8'h99, 4, 0);
        do_txn(2, 16'h9000, 8'h00, 8'h56, 8'h78, 8'h11, 5, 0);
        do_txn(1, 16'hFFFF, 8'hE1, 8'h00, 8'h00, 8'h00, 9, 0);
        do_txn(2, 16'h2222, 8'h00, 8'h01, 8'h02, 8'h5A, 10, 4);
        do_txn(0, 16'h0001, 8'h00, 8'h00, 8'h00, 8'hC3, 0, 0);

        for (int i = 0; i < 60; i++) begin
            do_txn(int'($urandom_range(2)), 16'($urandom), 8'($urandom),
                   8'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(6)), 0);
        end

        @(negedge CLK);
        check_idle("final", ADDR_OUT === ADDR_OUT ? ADDR_OUT : 16'h0,
                   exp_rdata, exp_dout);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
